// File: rtl/tmc2130_pkg.sv
// TMC2130 register map, driver init table and controller FSM encoding.
package tmc2130_pkg;

  // Register addresses (7-bit, bit 7 selects write).
  localparam logic [7:0] GCONF      = 8'h00;
  localparam logic [7:0] GSTAT      = 8'h01;
  localparam logic [7:0] IHOLD_IRUN = 8'h10;
  localparam logic [7:0] TPOWERDOWN = 8'h11;
  localparam logic [7:0] TPWMTHRS   = 8'h13;
  localparam logic [7:0] THIGH      = 8'h15;
  localparam logic [7:0] CHOPCONF   = 8'h6C;
  localparam logic [7:0] DRV_STATUS = 8'h6F;
  localparam logic [7:0] PWMCONF    = 8'h70;
  localparam logic [7:0] WRITE_ADDR = 8'h80;

  localparam int unsigned FRAME_W  = 40;
  localparam int unsigned INIT_LEN = 9;

  // GSTAT is read twice: the first read returns stale data and clears the flags.
  localparam logic [FRAME_W-1:0] INIT_TABLE [INIT_LEN] = '{
    {GSTAT, 32'h0000_0000},
    {GSTAT, 32'h0000_0000},
    {WRITE_ADDR | GCONF,      32'h0000_0021},
    {WRITE_ADDR | CHOPCONF,   32'h300a_8188},
    {WRITE_ADDR | IHOLD_IRUN, 32'h0008_0f0f},
    {WRITE_ADDR | TPOWERDOWN, 32'h0000_000a},
    {WRITE_ADDR | TPWMTHRS,   32'h0000_01f4},
    {WRITE_ADDR | PWMCONF,    32'h0004_08c8},
    {WRITE_ADDR | THIGH,      32'h0000_0032}
  };

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StNextCh,
    StRun,
    StPollWait
  } ctrl_state_e;

endpackage

// File: rtl/step_gen.sv
// One STEP channel: 50% duty square wave with a half-period of speed_in clocks.
// A running high phase always completes before the output parks low.
module step_gen #(
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                active_in,
  input  logic                enable_in,
  input  logic [PERIOD_W-1:0] speed_in,
  output logic                step_out
);

  logic                step_q, step_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  // Half-period in use; 0 marks the parked (idle) state.
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                run;

  assign run = enable_in & (speed_in != '0);

  // Next-state: start, count, toggle (resampling speed) or park low.
  always_comb begin
    step_d   = step_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    if (!active_in) begin
      step_d   = 1'b0;
      cnt_d    = '0;
      period_d = '0;
    end else if (!step_q && !run) begin
      cnt_d    = '0;
      period_d = '0;
    end else if (period_q == '0) begin
      step_d   = 1'b1;
      cnt_d    = '0;
      period_d = speed_in;
    end else if (cnt_q == period_q - 1'b1) begin
      step_d   = ~step_q & run;
      cnt_d    = '0;
      period_d = run ? speed_in : '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      step_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  // Losing init_done must silence the pin in the same cycle.
  assign step_out = step_q & active_in;

endmodule

// File: rtl/stepper_array_ctrl.sv
// N-channel TMC2130 controller: walks every driver through the SPI init table, then runs
// one STEP generator per channel. Optional DRV_STATUS polling in RUN is compiled in with
// the MOTOR_STATUS_POLL_EN macro.
module stepper_array_ctrl
  import tmc2130_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned SPI_W    = 40,
  parameter int unsigned TIMEOUT  = 4096,
  localparam int unsigned CS_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     reinit_in,
  output logic [SPI_W-1:0]         spi_data_out,
  output logic [CS_W-1:0]          spi_cs_sel_out,
  output logic                     spi_send_out,
  input  logic                     spi_ready_in,
  input  logic [SPI_W-1:0]         spi_data_in,
  input  logic [N_CH-1:0]          step_enable_in,
  input  logic [N_CH*PERIOD_W-1:0] speed_in,
  output logic [N_CH-1:0]          step_out,
  output logic                     init_done_out,
  output logic [N_CH-1:0]          init_error_out,
  output logic [N_CH*32-1:0]       status_out,
  output logic [N_CH-1:0]          status_valid_out
);

  localparam int unsigned IDX_W = $clog2(INIT_LEN);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CS_W-1:0]  LAST_CH  = CS_W'(N_CH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic [CS_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             send_q, send_d;
  logic [SPI_W-1:0] data_q, data_d;
  logic [CS_W-1:0]  cs_q, cs_d;
  logic             prev_ready_q;
  logic             init_done_q, init_done_d;
  logic [N_CH-1:0]  init_error_q, init_error_d;
  logic             done;
  logic             timeout;

  // Completion is the rising edge of ready, not its level.
  assign done    = spi_ready_in & ~prev_ready_q;
  assign timeout = (tmr_q == TMR_LAST);

  // Init / poll sequencer next-state.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    send_d       = send_q;
    data_d       = data_q;
    cs_d         = cs_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    unique case (state_q)
      StIdle: begin
        ch_d    = '0;
        idx_d   = '0;
        state_d = StIssue;
      end
      StIssue: begin
        data_d  = SPI_W'(INIT_TABLE[idx_q]);
        cs_d    = ch_q;
        send_d  = 1'b1;
        tmr_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (done) begin
          send_d = 1'b0;
          idx_d  = idx_q + 1'b1;
          state_d = (idx_q == LAST_IDX) ? StNextCh : StIssue;
        end else if (timeout) begin
          // A silent driver forfeits the rest of its table.
          send_d             = 1'b0;
          init_error_d[ch_q] = 1'b1;
          state_d            = StNextCh;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StNextCh: begin
        idx_d = '0;
        if (ch_q == LAST_CH) begin
          ch_d        = '0;
          init_done_d = 1'b1;
          state_d     = StRun;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StIssue;
        end
      end
      StRun: begin
`ifdef MOTOR_STATUS_POLL_EN
        data_d  = SPI_W'({DRV_STATUS, 32'h0000_0000});
        cs_d    = ch_q;
        send_d  = 1'b1;
        tmr_d   = '0;
        state_d = StPollWait;
`endif
      end
      StPollWait: begin
`ifdef MOTOR_STATUS_POLL_EN
        if (done || timeout) begin
          send_d  = 1'b0;
          ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          state_d = StRun;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`else
        state_d = StRun;
`endif
      end
      default: state_d = StIdle;
    endcase
    // Reinit wins over everything, including a ready edge in the same cycle.
    if (reinit_in) begin
      state_d      = StIdle;
      ch_d         = '0;
      idx_d        = '0;
      tmr_d        = '0;
      send_d       = 1'b0;
      init_done_d  = 1'b0;
      init_error_d = '0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      idx_q        <= '0;
      tmr_q        <= '0;
      send_q       <= 1'b0;
      data_q       <= '0;
      cs_q         <= '0;
      prev_ready_q <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      send_q       <= send_d;
      data_q       <= data_d;
      cs_q         <= cs_d;
      prev_ready_q <= spi_ready_in;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
    end
  end

  assign spi_data_out   = data_q;
  assign spi_cs_sel_out = cs_q;
  assign spi_send_out   = send_q;
  assign init_done_out  = init_done_q;
  assign init_error_out = init_error_q;

`ifdef MOTOR_STATUS_POLL_EN
  logic [N_CH-1:0][31:0] status_q, status_d;
  logic [N_CH-1:0]       status_valid_q, status_valid_d;
  logic                  have_prev_q, have_prev_d;
  logic [CS_W-1:0]       prev_ch_q, prev_ch_d;
  logic                  unused_spi_hi;

  // The driver answers a poll on the following frame, so each completed frame carries the
  // status of the previously polled channel; the first answer after RUN entry is stale.
  always_comb begin
    status_d       = status_q;
    status_valid_d = '0;
    have_prev_d    = have_prev_q;
    prev_ch_d      = prev_ch_q;
    if (reinit_in) begin
      have_prev_d = 1'b0;
    end else if (state_q == StPollWait) begin
      if (done) begin
        if (have_prev_q) begin
          status_d[prev_ch_q]       = spi_data_in[31:0];
          status_valid_d[prev_ch_q] = 1'b1;
        end
        have_prev_d = 1'b1;
        prev_ch_d   = ch_q;
      end else if (timeout) begin
        have_prev_d = 1'b0;
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      status_q       <= '0;
      status_valid_q <= '0;
      have_prev_q    <= 1'b0;
      prev_ch_q      <= '0;
    end else begin
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      have_prev_q    <= have_prev_d;
      prev_ch_q      <= prev_ch_d;
    end
  end

  assign status_out       = status_q;
  assign status_valid_out = status_valid_q;
  assign unused_spi_hi    = ^spi_data_in[SPI_W-1:32];
`else
  logic unused_spi_data;

  assign status_out       = '0;
  assign status_valid_out = '0;
  assign unused_spi_data  = ^spi_data_in;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_step
    step_gen #(
      .PERIOD_W (PERIOD_W)
    ) u_step_gen (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .active_in (init_done_q),
      .enable_in (step_enable_in[g]),
      .speed_in  (speed_in[g*PERIOD_W +: PERIOD_W]),
      .step_out  (step_out[g])
    );
  end

endmodule

// File: tb/tb_stepper_array_ctrl.sv
// Bench for stepper_array_ctrl: SPI slave model with random latency, init frame scoreboard,
// STEP phase-length checks, timeout, reinit and (with MOTOR_STATUS_POLL_EN) status polling.
module tb_stepper_array_ctrl;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned SPI_W    = 40;
  localparam int unsigned TIMEOUT  = 300;
  localparam int unsigned CS_W     = 1;

  logic                     clk = 1'b0;
  logic                     reset_in;
  logic                     reinit_in;
  logic [SPI_W-1:0]         spi_data_out;
  logic [CS_W-1:0]          spi_cs_sel_out;
  logic                     spi_send_out;
  logic                     spi_ready_in;
  logic [SPI_W-1:0]         spi_data_in;
  logic [N_CH-1:0]          step_enable_in;
  logic [N_CH*PERIOD_W-1:0] speed_in;
  logic [N_CH-1:0]          step_out;
  logic                     init_done_out;
  logic [N_CH-1:0]          init_error_out;
  logic [N_CH*32-1:0]       status_out;
  logic [N_CH-1:0]          status_valid_out;

  stepper_array_ctrl #(
    .N_CH     (N_CH),
    .PERIOD_W (PERIOD_W),
    .SPI_W    (SPI_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .reinit_in        (reinit_in),
    .spi_data_out     (spi_data_out),
    .spi_cs_sel_out   (spi_cs_sel_out),
    .spi_send_out     (spi_send_out),
    .spi_ready_in     (spi_ready_in),
    .spi_data_in      (spi_data_in),
    .step_enable_in   (step_enable_in),
    .speed_in         (speed_in),
    .step_out         (step_out),
    .init_done_out    (init_done_out),
    .init_error_out   (init_error_out),
    .status_out       (status_out),
    .status_valid_out (status_valid_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // SPI slave model state
  int              lat_min = 10;
  int              lat_max = 10;
  logic [N_CH-1:0] hang_mask = '0;
  logic [31:0]     status_val [N_CH];
  logic [63:0]     log_frame [$];
  time             log_t [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frames a TMC2130 expects during init, straight from its register map.
  function automatic logic [39:0] exp_frame(input int idx);
    case (idx)
      0, 1:    return 40'h01_0000_0000;
      2:       return 40'h80_0000_0021;
      3:       return 40'hEC_300A_8188;
      4:       return 40'h90_0008_0F0F;
      5:       return 40'h91_0000_000A;
      6:       return 40'h93_0000_01F4;
      7:       return 40'hF0_0004_08C8;
      default: return 40'h95_0000_0032;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave: ready rises some cycles after send is seen, drops once send drops. Replies carry
  // the status of whichever channel the previous completed frame addressed.
  initial begin : spi_model
    bit busy = 1'b0;
    int cnt  = 0;
    int prev_cs = 0;
    spi_ready_in = 1'b0;
    spi_data_in  = '0;
    forever begin
      tick();
      if (!spi_send_out) begin
        spi_ready_in = 1'b0;
        busy         = 1'b0;
      end else if (!busy) begin
        busy = 1'b1;
        log_frame.push_back({24'(spi_cs_sel_out), spi_data_out});
        log_t.push_back($time);
        cnt = hang_mask[spi_cs_sel_out] ? -1 : int'($urandom_range(lat_min, lat_max));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_ready_in = 1'b1;
          spi_data_in  = {8'h00, status_val[prev_cs]};
          prev_cs      = int'(spi_cs_sel_out);
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_frame.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(log_frame.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (init_done_out !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(init_done_out), 64'd1);
  endtask

  // Compare n logged frames from position base against a full init of all channels.
  task automatic check_frames(input int base, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [63:0] obs;
      obs = (base + i < log_frame.size()) ? log_frame[base + i] : '1;
      check($sformatf("%s_frame%0d", tag, i), obs, {24'(i / 9), exp_frame(i % 9)});
    end
  endtask

  // Cycles until step_out[0] reaches lvl (bounded).
  task automatic phase(input logic lvl, input int budget, output int len);
    len = 0;
    while (step_out[0] !== lvl && len < budget) begin
      tick();
      len++;
    end
  endtask

  task automatic set_speed(input int ch, input int val);
    speed_in[ch*PERIOD_W +: PERIOD_W] = PERIOD_W'(val);
  endtask

  task automatic pulse_reinit();
    reinit_in = 1'b1;
    tick();
    check("reinit_send", 64'(spi_send_out), 64'd0);
    check("reinit_step", 64'(step_out), 64'd0);
    check("reinit_done", 64'(init_done_out), 64'd0);
    check("reinit_err", 64'(init_error_out), 64'd0);
    reinit_in = 1'b0;
  endtask

  initial begin : main
    int s1, s2, len, highs, t_lo;
    time t_err;
    reset_in       = 1'b1;
    reinit_in      = 1'b0;
    step_enable_in = '0;
    speed_in       = '0;
    status_val[0]  = 32'hA5A5_0001;
    status_val[1]  = $urandom | 32'h1;

    // Reset state
    repeat (3) tick();
    check("rst_step", 64'(step_out), 64'd0);
    check("rst_done", 64'(init_done_out), 64'd0);
    check("rst_err", 64'(init_error_out), 64'd0);
    check("rst_send", 64'(spi_send_out), 64'd0);
    check("rst_data", 64'(spi_data_out), 64'd0);
    check("rst_cs", 64'(spi_cs_sel_out), 64'd0);
    reset_in = 1'b0;

    // Full init with a fixed 10-cycle slave
    wait_log(18, 18 * 20 + 50, "init_18_frames");
    check("done_before_last_ready", 64'(init_done_out), 64'd0);
    wait_done(60, "init_done");
    check_frames(0, 18, "init");
    check("init_no_err", 64'(init_error_out), 64'd0);
`ifndef MOTOR_STATUS_POLL_EN
    repeat (40) tick();
    check("run_frame_count", 64'(log_frame.size()), 64'd18);
    check("run_send_idle", 64'(spi_send_out), 64'd0);
    check("status_tied", 64'(status_out), 64'd0);
    check("status_valid_tied", 64'(status_valid_out), 64'd0);
`endif

    // STEP: half-period equals speed
    s1 = int'($urandom_range(3, 9));
    s2 = int'($urandom_range(2, 9));
    set_speed(0, s1);
    step_enable_in[0] = 1'b1;
    phase(1'b1, 10, len);
    check("step_start", 64'(step_out[0]), 64'd1);
    phase(1'b0, 40, len);
    check("step_high1", 64'(len), 64'(s1));
    phase(1'b1, 40, len);
    check("step_low1", 64'(len), 64'(s1));
    phase(1'b0, 40, len);
    check("step_high2", 64'(len), 64'(s1));
    phase(1'b1, 40, len);
    // Speed change mid-high takes effect only from the next toggle
    tick();
    tick();
    set_speed(0, s2);
    phase(1'b0, 40, len);
    check("chg_high_old", 64'(len + 2), 64'(s1));
    phase(1'b1, 40, len);
    check("chg_low_new", 64'(len), 64'(s2));
    phase(1'b0, 40, len);
    check("chg_high_new", 64'(len), 64'(s2));
    check("step_ch1_idle", 64'(step_out[1]), 64'd0);

    // Disable mid-high: phase finishes, then parks low
    phase(1'b1, 40, len);
    tick();
    step_enable_in[0] = 1'b0;
    phase(1'b0, 40, len);
    check("dis_finish_high", 64'(len + 1), 64'(s2));
    highs = 0;
    repeat (40) begin
      tick();
      if (step_out[0] !== 1'b0) highs++;
    end
    check("dis_parked", 64'(highs), 64'd0);
    step_enable_in[0] = 1'b1;
    set_speed(0, 0);
    highs = 0;
    repeat (40) begin
      tick();
      if (step_out[0] !== 1'b0) highs++;
    end
    check("speed0_parked", 64'(highs), 64'd0);

    // Reinit while stepping forces STEP low at once; reinit again during entry 4
    set_speed(0, 4);
    phase(1'b1, 10, len);
    tick();
    check("pre_reinit_step", 64'(step_out[0]), 64'd1);
    pulse_reinit();
    log_frame.delete();
    log_t.delete();
    lat_min = 3;
    lat_max = 12;
    wait_log(4, 200, "reinit_4_frames");
    check("entry4_send", 64'(spi_send_out), 64'd1);
    pulse_reinit();
    wait_log(5, 20, "restart_frame");
    check("restart_gstat", (log_frame.size() > 4) ? log_frame[4] : '1,
          {24'd0, exp_frame(0)});
    wait_done(18 * 20 + 50, "reinit_done");
    check_frames(4, 18, "reinit");

    // Channel 1 silent: timeout flags it and skips its remaining entries
    hang_mask = 2'b10;
    pulse_reinit();
    log_frame.delete();
    log_t.delete();
    wait_log(10, 9 * 20 + 50, "to_10_frames");
    t_lo = 0;
    while (init_error_out === '0 && t_lo < TIMEOUT + 50) begin
      tick();
      t_lo++;
    end
    t_err = $time;
    check("to_err", 64'(init_error_out), 64'b10);
    check("to_window", 64'(log_t.size() >= 10 &&
          (t_err - log_t[9]) / 10 >= TIMEOUT && (t_err - log_t[9]) / 10 <= TIMEOUT + 1),
          64'd1);
    wait_done(10, "to_done");
    check("to_ch1_first", (log_frame.size() > 9) ? log_frame[9] : '1, {24'd1, exp_frame(0)});
    repeat (20) tick();
`ifndef MOTOR_STATUS_POLL_EN
    check("to_skip_rest", 64'(log_frame.size()), 64'd10);
`endif
    check("to_sticky", 64'(init_error_out), 64'b10);
    hang_mask = '0;
    pulse_reinit();
    wait_done(18 * 20 + 50, "clean_done");

`ifdef MOTOR_STATUS_POLL_EN
    // First poll answer after RUN is stale; ch0's status arrives on the ch1 frame
    t_lo = 0;
    while (status_valid_out === '0 && t_lo < 400) begin
      tick();
      t_lo++;
    end
    check("poll_first_valid", 64'(status_valid_out), 64'b01);
    check("poll_status0", 64'(status_out[31:0]), 64'(status_val[0]));
    check("poll_late_frame", (log_frame.size() > 0) ? log_frame[log_frame.size() - 1] : '1,
          {24'd1, 8'h6F, 32'h0});
    tick();
    check("poll_pulse_width", 64'(status_valid_out), 64'd0);
    t_lo = 0;
    while (status_valid_out === '0 && t_lo < 400) begin
      tick();
      t_lo++;
    end
    check("poll_second_valid", 64'(status_valid_out), 64'b10);
    check("poll_status1", 64'(status_out[63:32]), 64'(status_val[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
